// File: rtl/simmem_wresp_bank.sv
// Write-response bank: reserves entries, stores memory B responses, releases them in per-ID order.
// Define SIMMEM_WRESP_NO_DELAY_EN to ignore release_en_i (zero-delay pass-through).
module simmem_wresp_bank #(
    parameter int unsigned Capacity  = 16,
    parameter int unsigned AddrWidth = $clog2(Capacity),
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned RespWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 rsv_valid_i,
    output logic                 rsv_ready_o,
    input  logic [IdWidth-1:0]   rsv_id_i,
    output logic [AddrWidth-1:0] rsv_iid_o,

    input  logic                 wresp_in_valid_i,
    output logic                 wresp_in_ready_o,
    input  logic [IdWidth-1:0]   wresp_in_id_i,
    input  logic [RespWidth-1:0] wresp_in_resp_i,

    input  logic [Capacity-1:0]  release_en_i,
    output logic [Capacity-1:0]  released_addr_onehot_o,

    output logic                 wresp_out_valid_o,
    input  logic                 wresp_out_ready_i,
    output logic [IdWidth-1:0]   wresp_out_id_o,
    output logic [RespWidth-1:0] wresp_out_resp_o
);

    logic [Capacity-1:0]  v_q, v_d, f_q, f_d;
    logic [IdWidth-1:0]   id_q    [Capacity];
    logic [RespWidth-1:0] resp_q  [Capacity];
    logic [Capacity-1:0]  older_q [Capacity];
    logic [Capacity-1:0]  older_d [Capacity];

    logic [Capacity-1:0]  rel_mask;
    logic [Capacity-1:0]  head, elig;
    logic [Capacity-1:0]  fill_cand, fill_tgt;
    logic [Capacity-1:0]  rsv_onehot, fill_onehot, win_onehot, win_clr;
    logic [AddrWidth-1:0] rsv_iid;
    logic                 rsv_found, fill_found, win_found;
    logic                 rsv_fire, fill_fire, load;
    logic [IdWidth-1:0]   win_id;
    logic [RespWidth-1:0] win_resp;

    logic                 out_valid_q;
    logic [IdWidth-1:0]   out_id_q;
    logic [RespWidth-1:0] out_resp_q;
    logic [Capacity-1:0]  pulse_q;

`ifdef SIMMEM_WRESP_NO_DELAY_EN
    logic unused_release_en;
    assign unused_release_en = ^release_en_i;
    assign rel_mask = '1;
`else
    assign rel_mask = release_en_i;
`endif

    // Lowest free entry is offered for reservation.
    always_comb begin
        rsv_iid    = '0;
        rsv_found  = 1'b0;
        rsv_onehot = '0;
        for (int unsigned i = 0; i < Capacity; i++) begin
            if (!v_q[i] && !rsv_found) begin
                rsv_found     = 1'b1;
                rsv_iid       = AddrWidth'(i);
                rsv_onehot[i] = 1'b1;
            end
        end
    end

    assign rsv_ready_o = |(~v_q);
    assign rsv_iid_o   = rsv_iid;
    assign rsv_fire    = rsv_valid_i & rsv_ready_o;

    // Fill target is the oldest unfilled reservation carrying the incoming BID.
    always_comb begin
        for (int unsigned i = 0; i < Capacity; i++) begin
            fill_cand[i] = v_q[i] & ~f_q[i] & (id_q[i] == wresp_in_id_i);
        end
        for (int unsigned i = 0; i < Capacity; i++) begin
            fill_tgt[i] = fill_cand[i] & ~|(older_q[i] & fill_cand);
        end
    end

    always_comb begin
        fill_onehot = '0;
        fill_found  = 1'b0;
        for (int unsigned i = 0; i < Capacity; i++) begin
            if (fill_tgt[i] && !fill_found) begin
                fill_found     = 1'b1;
                fill_onehot[i] = 1'b1;
            end
        end
    end

    assign wresp_in_ready_o = |fill_tgt;
    assign fill_fire        = wresp_in_valid_i & wresp_in_ready_o;

    // An entry is the per-ID head when no older live entry shares its id.
    always_comb begin
        head = '1;
        for (int unsigned i = 0; i < Capacity; i++) begin
            for (int unsigned j = 0; j < Capacity; j++) begin
                if (older_q[i][j] && v_q[j] && (id_q[j] == id_q[i])) begin
                    head[i] = 1'b0;
                end
            end
        end
    end

    assign elig = v_q & f_q & rel_mask & head;

    always_comb begin
        win_onehot = '0;
        win_found  = 1'b0;
        win_id     = '0;
        win_resp   = '0;
        for (int unsigned i = 0; i < Capacity; i++) begin
            if (elig[i] && !win_found) begin
                win_found     = 1'b1;
                win_onehot[i] = 1'b1;
                win_id        = id_q[i];
                win_resp      = resp_q[i];
            end
        end
    end

    assign load    = (~out_valid_q | wresp_out_ready_i) & win_found;
    assign win_clr = load ? win_onehot : '0;

    always_comb begin
        v_d = v_q;
        f_d = f_q;
        if (rsv_fire) begin
            v_d = v_d | rsv_onehot;
            f_d = f_d & ~rsv_onehot;
        end
        if (fill_fire) begin
            f_d = f_d | fill_onehot;
        end
        v_d = v_d & ~win_clr;
    end

    // The entry freed this cycle must not be recorded as older than a new reservation.
    always_comb begin
        for (int unsigned i = 0; i < Capacity; i++) begin
            older_d[i] = older_q[i] & ~win_clr;
            if (rsv_fire && rsv_onehot[i]) begin
                older_d[i] = v_q & ~win_clr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            f_q <= '0;
            for (int unsigned i = 0; i < Capacity; i++) begin
                id_q[i]    <= '0;
                resp_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            f_q <= f_d;
            for (int unsigned i = 0; i < Capacity; i++) begin
                older_q[i] <= older_d[i];
                if (rsv_fire && rsv_onehot[i]) begin
                    id_q[i] <= rsv_id_i;
                end
                if (fill_fire && fill_onehot[i]) begin
                    resp_q[i] <= wresp_in_resp_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_resp_q  <= '0;
            pulse_q     <= '0;
        end else begin
            pulse_q <= win_clr;
            if (load) begin
                out_valid_q <= 1'b1;
                out_id_q    <= win_id;
                out_resp_q  <= win_resp;
            end else if (wresp_out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign wresp_out_valid_o      = out_valid_q;
    assign wresp_out_id_o         = out_id_q;
    assign wresp_out_resp_o       = out_resp_q;
    assign released_addr_onehot_o = pulse_q;

endmodule
